// File: rtl/core_pkg.sv
// Shared core definitions: functional-unit codes, ALU opcodes, default widths
// and the dispatch operand payload.
package core_pkg;

    localparam int unsigned CORE_DATA_W = 32;
    localparam int unsigned CORE_TAG_W  = 4;
    localparam int unsigned CORE_OP_W   = 4;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_LSQ = 2'd1,
        FU_BRA = 2'd2
    } fu_e;

    typedef enum logic [CORE_OP_W-1:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

    typedef struct packed {
        logic                   rdy;
        logic [CORE_TAG_W-1:0]  tag;
        logic [CORE_DATA_W-1:0] val;
    } disp_opnd_t;

endpackage

// File: rtl/rs_alu_if.sv
// Dispatch / CDB / issue bundle of the ALU reservation station.
interface rs_alu_if
    import core_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = CORE_DATA_W,
    parameter int unsigned TAG_W  = CORE_TAG_W,
    parameter int unsigned OP_W   = CORE_OP_W
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              flush;
    logic              disp_valid;
    logic [OP_W-1:0]   disp_op;
    logic [TAG_W-1:0]  disp_rob_tag;
    logic              disp_src1_rdy;
    logic [TAG_W-1:0]  disp_src1_tag;
    logic [DATA_W-1:0] disp_src1_val;
    logic              disp_src2_rdy;
    logic [TAG_W-1:0]  disp_src2_tag;
    logic [DATA_W-1:0] disp_src2_val;
    logic              full;
    logic [CNT_W-1:0]  count;
    logic              cdb_valid;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_val;
    logic              issue_valid;
    logic              issue_ready;
    logic [OP_W-1:0]   issue_op;
    logic [TAG_W-1:0]  issue_rob_tag;
    logic [DATA_W-1:0] issue_src1;
    logic [DATA_W-1:0] issue_src2;

    modport master (
        output flush, disp_valid, disp_op, disp_rob_tag,
               disp_src1_rdy, disp_src1_tag, disp_src1_val,
               disp_src2_rdy, disp_src2_tag, disp_src2_val,
               cdb_valid, cdb_tag, cdb_val, issue_ready,
        input  full, count, issue_valid, issue_op, issue_rob_tag,
               issue_src1, issue_src2
    );

    modport slave (
        input  flush, disp_valid, disp_op, disp_rob_tag,
               disp_src1_rdy, disp_src1_tag, disp_src1_val,
               disp_src2_rdy, disp_src2_tag, disp_src2_val,
               cdb_valid, cdb_tag, cdb_val, issue_ready,
        output full, count, issue_valid, issue_op, issue_rob_tag,
               issue_src1, issue_src2
    );

endinterface

// File: rtl/rs_select.sv
// Generic N-wide picker: among requesting slots, grant the smallest key,
// ties resolved toward the lowest index. Shared by all reservation stations.
module rs_select #(
    parameter int unsigned N     = 4,
    parameter int unsigned KEY_W = 2,
    parameter int unsigned IDX_W = $clog2(N)
) (
    input  logic [N-1:0]       req_i,
    input  logic [N*KEY_W-1:0] key_i,
    output logic [N-1:0]       gnt_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               any_o
);

    logic             found;
    logic [KEY_W-1:0] best;
    logic [IDX_W-1:0] idx;

    always_comb begin
        found = 1'b0;
        best  = '0;
        idx   = '0;
        for (int i = 0; i < int'(N); i++) begin
            if (req_i[i] && (!found || key_i[i*KEY_W +: KEY_W] < best)) begin
                found = 1'b1;
                best  = key_i[i*KEY_W +: KEY_W];
                idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (found) gnt_o[idx] = 1'b1;
    end

    assign idx_o = idx;
    assign any_o = found;

endmodule

// File: rtl/rs_alu.sv
// ALU reservation station: holds dispatched micro-ops until both operands are
// ready, wakes them from the CDB, issues one per cycle. Macro RS_AGE_ORDER_EN
// switches select from lowest-index to oldest-first.
module rs_alu
    import core_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned DATA_W = CORE_DATA_W,
    parameter int unsigned TAG_W  = CORE_TAG_W,
    parameter int unsigned OP_W   = CORE_OP_W
) (
    input logic     clk,
    input logic     rst,
    rs_alu_if.slave rs
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic              rdy;
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] val;
    } opnd_t;

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [OP_W-1:0]  op_q   [DEPTH];
    logic [OP_W-1:0]  op_d   [DEPTH];
    logic [TAG_W-1:0] rtag_q [DEPTH];
    logic [TAG_W-1:0] rtag_d [DEPTH];
    opnd_t            s1_q   [DEPTH];
    opnd_t            s1_d   [DEPTH];
    opnd_t            s2_q   [DEPTH];
    opnd_t            s2_d   [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic                   full_c;
    logic                   disp_fire;
    logic                   issue_fire;
    logic [IDX_W-1:0]       free_idx;
    logic [DEPTH-1:0]       eligible;
    logic [DEPTH*IDX_W-1:0] key_flat;
    logic [DEPTH-1:0]       sel_gnt;
    logic [IDX_W-1:0]       sel_idx;
    logic                   sel_any;

    function automatic opnd_t wake(input opnd_t s, input logic v,
                                   input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] d);
        opnd_t r;
        r = s;
        if (v && !s.rdy && s.tag == t) begin
            r.rdy = 1'b1;
            r.val = d;
        end
        return r;
    endfunction

    assign full_c     = (count_q == CNT_W'(DEPTH));
    assign disp_fire  = rs.disp_valid && !full_c;
    assign issue_fire = sel_any && rs.issue_ready;

    always_comb begin
        free_idx = '0;
        for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) begin
            eligible[i] = valid_q[i] && s1_q[i].rdy && s2_q[i].rdy;
        end
    end

`ifdef RS_AGE_ORDER_EN
    // Ages stay a dense 0..count-1 permutation; 0 is the oldest entry.
    logic [IDX_W-1:0] age_q [DEPTH];
    logic [IDX_W-1:0] age_d [DEPTH];

    always_comb begin
        age_d = age_q;
        if (rs.flush) begin
            for (int j = 0; j < int'(DEPTH); j++) age_d[j] = '0;
        end else begin
            if (issue_fire) begin
                for (int j = 0; j < int'(DEPTH); j++) begin
                    if (valid_q[j] && age_q[j] > age_q[sel_idx]) age_d[j] = age_q[j] - IDX_W'(1);
                end
            end
            if (disp_fire) age_d[free_idx] = IDX_W'(count_q - CNT_W'(issue_fire));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < int'(DEPTH); j++) age_q[j] <= '0;
        end else begin
            age_q <= age_d;
        end
    end

    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) key_flat[i*IDX_W +: IDX_W] = age_q[i];
    end
`else
    always_comb begin
        for (int i = 0; i < int'(DEPTH); i++) key_flat[i*IDX_W +: IDX_W] = IDX_W'(i);
    end
`endif

    rs_select #(
        .N     (DEPTH),
        .KEY_W (IDX_W),
        .IDX_W (IDX_W)
    ) u_select (
        .req_i (eligible),
        .key_i (key_flat),
        .gnt_o (sel_gnt),
        .idx_o (sel_idx),
        .any_o (sel_any)
    );

    // Next state: flush wins over wakeup, issue and dispatch.
    always_comb begin
        valid_d = valid_q;
        op_d    = op_q;
        rtag_d  = rtag_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        count_d = count_q;
        if (rs.flush) begin
            valid_d = '0;
            count_d = '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (valid_q[i]) begin
                    s1_d[i] = wake(s1_q[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_val);
                    s2_d[i] = wake(s2_q[i], rs.cdb_valid, rs.cdb_tag, rs.cdb_val);
                end
            end
            if (issue_fire) valid_d = valid_d & ~sel_gnt;
            if (disp_fire) begin
                valid_d[free_idx] = 1'b1;
                op_d[free_idx]    = rs.disp_op;
                rtag_d[free_idx]  = rs.disp_rob_tag;
                s1_d[free_idx]    = wake(opnd_t'{rs.disp_src1_rdy, rs.disp_src1_tag, rs.disp_src1_val},
                                         rs.cdb_valid, rs.cdb_tag, rs.cdb_val);
                s2_d[free_idx]    = wake(opnd_t'{rs.disp_src2_rdy, rs.disp_src2_tag, rs.disp_src2_val},
                                         rs.cdb_valid, rs.cdb_tag, rs.cdb_val);
            end
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(issue_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        op_q   <= op_d;
        rtag_q <= rtag_d;
        s1_q   <= s1_d;
        s2_q   <= s2_d;
    end

    assign rs.full          = full_c;
    assign rs.count         = count_q;
    assign rs.issue_valid   = sel_any;
    assign rs.issue_op      = op_q[sel_idx];
    assign rs.issue_rob_tag = rtag_q[sel_idx];
    assign rs.issue_src1    = s1_q[sel_idx].val;
    assign rs.issue_src2    = s2_q[sel_idx].val;

    // Upstream hazard logic must never dispatch into a full station.
    assert property (@(posedge clk) disable iff (rst) !(rs.disp_valid && full_c))
        else $error("rs_alu: dispatch while full, micro-op dropped");

endmodule

// File: tb/tb_rs_alu.sv
// Directed bench for rs_alu with a slot-level behavioural model and a
// per-cycle compare process.
module tb_rs_alu;
    import core_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned OP_W   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    rs_alu_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) bus ();

    rs_alu #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)) dut (
        .clk (clk),
        .rst (rst),
        .rs  (bus)
    );

    int nvec = 0;
    int nerr = 0;
    bit chk_en = 1'b0;

    typedef struct {
        bit                v;
        logic [OP_W-1:0]   op;
        logic [TAG_W-1:0]  rtag;
        bit                r1;
        logic [TAG_W-1:0]  t1;
        logic [DATA_W-1:0] v1;
        bit                r2;
        logic [TAG_W-1:0]  t2;
        logic [DATA_W-1:0] v2;
        int                seq;
    } m_ent_t;

    m_ent_t m [DEPTH];
    int     m_cnt = 0;
    int     seqn  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Ready micro-op with the highest select priority, or -1.
    function automatic int m_pick();
        int best;
        best = -1;
        for (int i = 0; i < int'(DEPTH); i++) begin
            if (m[i].v && m[i].r1 && m[i].r2) begin
`ifdef RS_AGE_ORDER_EN
                if (best < 0 || m[i].seq < m[best].seq) best = i;
`else
                if (best < 0) best = i;
`endif
            end
        end
        return best;
    endfunction

    always @(posedge clk) begin
        int sel;
        int fr;
        bit fi;
        bit fd;
        if (rst || bus.flush) begin
            for (int i = 0; i < int'(DEPTH); i++) m[i].v = 1'b0;
            m_cnt = 0;
        end else begin
            sel = m_pick();
            fi  = (sel >= 0) && bus.issue_ready;
            fd  = bus.disp_valid && (m_cnt < int'(DEPTH));
            fr  = -1;
            for (int i = 0; i < int'(DEPTH); i++) if (!m[i].v && fr < 0) fr = i;
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (m[i].v && bus.cdb_valid) begin
                    if (!m[i].r1 && m[i].t1 == bus.cdb_tag) begin m[i].r1 = 1'b1; m[i].v1 = bus.cdb_val; end
                    if (!m[i].r2 && m[i].t2 == bus.cdb_tag) begin m[i].r2 = 1'b1; m[i].v2 = bus.cdb_val; end
                end
            end
            if (fi) m[sel].v = 1'b0;
            if (fd) begin
                m[fr].v    = 1'b1;
                m[fr].op   = bus.disp_op;
                m[fr].rtag = bus.disp_rob_tag;
                m[fr].r1   = bus.disp_src1_rdy;
                m[fr].t1   = bus.disp_src1_tag;
                m[fr].v1   = bus.disp_src1_val;
                m[fr].r2   = bus.disp_src2_rdy;
                m[fr].t2   = bus.disp_src2_tag;
                m[fr].v2   = bus.disp_src2_val;
                if (bus.cdb_valid && !m[fr].r1 && m[fr].t1 == bus.cdb_tag) begin m[fr].r1 = 1'b1; m[fr].v1 = bus.cdb_val; end
                if (bus.cdb_valid && !m[fr].r2 && m[fr].t2 == bus.cdb_tag) begin m[fr].r2 = 1'b1; m[fr].v2 = bus.cdb_val; end
                m[fr].seq  = seqn;
                seqn++;
            end
            m_cnt = m_cnt + int'(fd) - int'(fi);
        end
    end

    always @(negedge clk) begin
        int s;
        if (chk_en) begin
            s = m_pick();
            chk("count", 32'(bus.count), 32'(m_cnt));
            chk("full", 32'(bus.full), 32'(m_cnt == int'(DEPTH)));
            chk("issue_valid", 32'(bus.issue_valid), 32'(s >= 0));
            if (s >= 0 && bus.issue_valid) begin
                chk("issue_op", 32'(bus.issue_op), 32'(m[s].op));
                chk("issue_rob_tag", 32'(bus.issue_rob_tag), 32'(m[s].rtag));
                chk("issue_src1", bus.issue_src1, m[s].v1);
                chk("issue_src2", bus.issue_src2, m[s].v2);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle();
        bus.disp_valid = 1'b0;
        bus.cdb_valid  = 1'b0;
        bus.flush      = 1'b0;
    endtask

    function automatic disp_opnd_t rdy(input logic [31:0] v);
        return '{1'b1, 4'd0, v};
    endfunction

    function automatic disp_opnd_t wt(input logic [3:0] t);
        return '{1'b0, t, 32'd0};
    endfunction

    task automatic disp(input logic [3:0] op, input logic [3:0] rt, input disp_opnd_t a, input disp_opnd_t b);
        bus.disp_valid    = 1'b1;
        bus.disp_op       = op;
        bus.disp_rob_tag  = rt;
        bus.disp_src1_rdy = a.rdy;
        bus.disp_src1_tag = a.tag;
        bus.disp_src1_val = a.val;
        bus.disp_src2_rdy = b.rdy;
        bus.disp_src2_tag = b.tag;
        bus.disp_src2_val = b.val;
    endtask

    task automatic cdb(input logic [3:0] t, input logic [31:0] v);
        bus.cdb_valid = 1'b1;
        bus.cdb_tag   = t;
        bus.cdb_val   = v;
    endtask

    task automatic drain(input int n);
        bus.issue_ready = 1'b1;
        repeat (n) tick();
        bus.issue_ready = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        bus.issue_ready = 1'b0;
        disp(4'd0, 4'd0, rdy(32'd0), rdy(32'd0));
        bus.disp_valid = 1'b0;
        cdb(4'd0, 32'd0);
        bus.cdb_valid = 1'b0;
        tick();
        tick();
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_issue_valid", 32'(bus.issue_valid), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // Fill with four ready micro-ops, ALU stalled.
        for (int k = 0; k < 4; k++) begin
            disp(4'(k), 4'(k + 1), rdy(32'(100 + k)), rdy(32'(200 + k)));
            tick();
        end
        idle();
        chk("t1_count", 32'(bus.count), 32'd4);
        chk("t1_full", 32'(bus.full), 32'd1);
        chk("t1_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t1_issue_tag", 32'(bus.issue_rob_tag), 32'd1);
        chk("t1_issue_src1", bus.issue_src1, 32'd100);

        // One issue, then one dispatch into the freed slot.
        bus.issue_ready = 1'b1;
        tick();
        bus.issue_ready = 1'b0;
        chk("t4_full_drop", 32'(bus.full), 32'd0);
        chk("t4_count_3", 32'(bus.count), 32'd3);
        disp(ALU_SUB, 4'd5, rdy(32'd105), rdy(32'd205));
        tick();
        idle();
        chk("t4_count_4", 32'(bus.count), 32'd4);
        chk("t4_full_back", 32'(bus.full), 32'd1);
`ifdef RS_AGE_ORDER_EN
        chk("t4_issue_tag", 32'(bus.issue_rob_tag), 32'd2);
`else
        chk("t4_issue_tag", 32'(bus.issue_rob_tag), 32'd5);
`endif
        drain(4);
        chk("t4_empty", 32'(bus.count), 32'd0);

        // Wakeup from CDB two cycles after dispatch.
        disp(ALU_SUB, 4'd6, wt(4'd5), rdy(32'd2));
        tick();
        idle();
        tick();
        chk("t2_wait", 32'(bus.issue_valid), 32'd0);
        cdb(4'd5, 32'h1234);
        tick();
        idle();
        chk("t2_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t2_issue_src1", bus.issue_src1, 32'h0000_1234);
        drain(1);

        // Dispatch-time bypass on src2.
        disp(ALU_AND, 4'd7, rdy(32'd3), wt(4'd3));
        cdb(4'd3, 32'hABCD);
        tick();
        idle();
        chk("t3_issue_valid", 32'(bus.issue_valid), 32'd1);
        chk("t3_issue_src2", bus.issue_src2, 32'h0000_ABCD);
        drain(1);

        // Flush with concurrent dispatch, wakeup and issue.
        disp(ALU_OR, 4'd8, wt(4'd9), rdy(32'd1));
        tick();
        disp(ALU_XOR, 4'd10, rdy(32'd2), rdy(32'd3));
        tick();
        disp(ALU_ADD, 4'd11, rdy(32'd4), wt(4'd12));
        tick();
        idle();
        chk("t5_count_3", 32'(bus.count), 32'd3);
        bus.flush = 1'b1;
        disp(ALU_ADD, 4'd12, rdy(32'd5), rdy(32'd6));
        cdb(4'd9, 32'd7);
        bus.issue_ready = 1'b1;
        tick();
        idle();
        bus.issue_ready = 1'b0;
        chk("t5_count_0", 32'(bus.count), 32'd0);
        chk("t5_full", 32'(bus.full), 32'd0);
        chk("t5_issue_valid", 32'(bus.issue_valid), 32'd0);
        disp(ALU_SUB, 4'd13, rdy(32'h55), rdy(32'h66));
        tick();
        idle();
        chk("t5_redisp_tag", 32'(bus.issue_rob_tag), 32'd13);
        chk("t5_redisp_src1", bus.issue_src1, 32'h55);
        drain(1);

        // Older A in a high slot vs younger B in slot 0, woken together.
        disp(ALU_ADD, 4'd1, rdy(32'd10), rdy(32'd11));
        tick();
        disp(ALU_ADD, 4'd2, rdy(32'd12), rdy(32'd13));
        tick();
        disp(ALU_SLL, 4'd3, wt(4'd7), rdy(32'd14));
        tick();
        idle();
        drain(2);
        chk("t6_count_1", 32'(bus.count), 32'd1);
        chk("t6_a_waits", 32'(bus.issue_valid), 32'd0);
        disp(ALU_SRL, 4'd4, wt(4'd7), rdy(32'd15));
        tick();
        idle();
        cdb(4'd7, 32'h77);
        tick();
        idle();
        chk("t6_issue_valid", 32'(bus.issue_valid), 32'd1);
`ifdef RS_AGE_ORDER_EN
        chk("t6_first", 32'(bus.issue_rob_tag), 32'd3);
`else
        chk("t6_first", 32'(bus.issue_rob_tag), 32'd4);
`endif
        chk("t6_src1", bus.issue_src1, 32'h77);
        drain(1);
`ifdef RS_AGE_ORDER_EN
        chk("t6_second", 32'(bus.issue_rob_tag), 32'd4);
`else
        chk("t6_second", 32'(bus.issue_rob_tag), 32'd3);
`endif
        drain(1);
        chk("t6_empty", 32'(bus.count), 32'd0);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/rs_alu.md
Name: rs_alu

Overview:
ALU reservation station of the out-of-order core.
- Accepts dispatched ALU micro-ops and holds them until both source operands are ready.
- Wakes waiting operands from the common data bus (CDB) and issues one ready micro-op per cycle to the ALU.
- Produces the full indication consumed by the hazard unit (RSALU_full) and obeys the global flush driven by branch misprediction.

Parameters:
DEPTH, 4, number of entries (power of 2, 2..16)
DATA_W, 32, operand width
TAG_W, 4, ROB tag width
OP_W, 4, ALU opcode width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  misprediction flush; clears all entries
disp_valid  in  1  dispatch request; already gated by hazard stall upstream
disp_op  in  OP_W  ALU opcode
disp_rob_tag  in  TAG_W  destination ROB tag
disp_src1_rdy  in  1  src1 value valid at dispatch
disp_src1_tag  in  TAG_W  src1 producer tag when not ready
disp_src1_val  in  DATA_W  src1 value when ready
disp_src2_rdy  in  1  as src1
disp_src2_tag  in  TAG_W  as src1
disp_src2_val  in  DATA_W  as src1
full  out  1  no free entry (to hazard unit RSALU_full)
count  out  $clog2(DEPTH)+1  occupied entries
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  broadcast ROB tag
cdb_val  in  DATA_W  broadcast result
issue_valid  out  1  selected entry presented to ALU
issue_ready  in  1  ALU accepts
issue_op  out  OP_W  opcode
issue_rob_tag  out  TAG_W  destination tag
issue_src1  out  DATA_W  operand 1
issue_src2  out  DATA_W  operand 2

Behaviour:
- Reset (rst=1 at posedge clk): all entry valid bits cleared, count=0, full=0, issue_valid=0, age state cleared.
- Entry fields: valid, op, rob_tag, and per source rdy/tag/val.
- full = (count==DEPTH). It is a combinational function of registered state only and has no dependence on disp_valid.
- Dispatch:
  - When disp_valid=1 and full=0, the lowest-index free entry is written at the clock edge.
  - disp_valid while full=1 is a protocol violation; the entry is dropped and an assertion fires.
- Dispatch-time CDB bypass: if cdb_valid and a not-ready dispatched source tag equals cdb_tag in the same cycle, that source is stored ready with value cdb_val.
- Wakeup: every valid entry with a not-ready source whose tag equals cdb_tag under cdb_valid captures cdb_val and sets rdy at the edge. A wake-up becomes visible for issue in the next cycle (1-cycle wakeup-to-issue).
- Select: an entry is eligible when valid and both sources are ready. Default policy picks the lowest-index eligible entry.
- Issue:
  - issue_valid is combinational from registered state.
  - The outputs stay stable while issue_valid=1 and issue_ready=0. Select may change only when new entries become eligible at higher priority.
  - On issue_valid & issue_ready, the selected entry is freed at the edge.
- Count update: count += dispatch_fire - issue_fire. Simultaneous dispatch and issue leaves count unchanged. A freed slot is reusable the following cycle, not the same cycle.
- Flush:
  - Highest priority after rst. All entries are invalidated at the edge and count=0.
  - Dispatch, wakeup and issue in the same cycle are discarded; issue_fire in a flush cycle is treated as squashed by the ROB.
- Empty: issue_valid=0, outputs hold last value (don't care).

Optional Feature:
RS_AGE_ORDER_EN
- Defined: each entry carries a $clog2(DEPTH)-bit age. On dispatch the new entry gets age=count-after-issue; ages of older entries above an issued entry decrement. Select picks the eligible entry with the smallest age (oldest first).
- Undefined: lowest-index select; no age storage.
- Both builds keep identical ports and full/count timing.

Decomposition:
- Shared package (core_pkg): FU_ALU/FU_LSQ/FU_BRA encodings, ALU opcode constants, TAG_W/DATA_W defaults, and the struct type for a dispatch operand (rdy, tag, val).
- One sub-module: rs_select — DEPTH-wide priority/age picker returning a one-hot grant and an index. It is reused by the LSQ and branch stations.

Test Plan:
1. Reset then dispatch four micro-ops with both sources ready (DEPTH=4), issue_ready=0 -> count=4, full=1 on the cycle after the fourth dispatch, issue_valid=1 presenting entry 0.
2. Dispatch op with src1 tag=5 not ready; cdb_valid, tag=5, val=0x1234 two cycles later -> issue_valid rises one cycle after the broadcast with issue_src1=0x1234.
3. Dispatch with src2 tag=3 in the same cycle cdb broadcasts tag=3 val=0xABCD -> entry stored ready, issue_valid next cycle, issue_src2=0xABCD.
4. Full RS, issue_ready=1 with disp_valid=1 the next cycle -> one issue then one dispatch, count returns to 4, no drop, full deasserts exactly one cycle.
5. Three entries valid, flush=1 with simultaneous disp_valid and cdb_valid -> count=0, full=0, issue_valid=0 next cycle; a later dispatch lands in entry 0.
6. With RS_AGE_ORDER_EN: dispatch A into idx2 (older), B into idx0, both become ready the same cycle -> A issues first; without the macro B issues first.
